// File: rtl/nes_poll_reader.sv
// Host-side NES controller poller: frames a latch pulse and eight sclk half-periods
// per poll tick, deserializes the active-low serial stream and publishes button bits.
module nes_poll_reader #(
  parameter int POLL_CYCLES  = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       data_in,
  output logic       latch,
  output logic       sclk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       changed
);

  localparam int PW   = $clog2(POLL_CYCLES);
  localparam int TMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   poll_cnt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            din_p0, din_p1;
  logic            tick;
  logic            publish;

  assign tick = (poll_cnt == POLL_LAST);

  // Stage p0/p1: two-flop synchronizer on the controller's serial output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_p0 <= 1'b1;
      din_p1 <= 1'b1;
    end else begin
      din_p0 <= data_in;
      din_p1 <= din_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    publish   = 1'b0;
    case (state)
      S_IDLE: begin
        tmr_nxt = '0;
        if (tick && en) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (tmr == LATCH_LAST) begin
          tmr_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (tmr == HALF_LAST) begin
          tmr_nxt        = '0;
          shift_nxt[idx] = din_p1;
          if (idx == 3'd7) begin
            publish   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_HIGH;
          end
        end
      end
      S_HIGH: begin
        if (tmr == HALF_LAST) begin
          tmr_nxt   = '0;
          idx_nxt   = idx + 1'b1;
          state_nxt = S_LOW;
        end
      end
      S_DONE: begin
        tmr_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        tmr_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tmr     <= '0;
      idx     <= '0;
      shift   <= '0;
      latch   <= 1'b0;
      sclk    <= 1'b0;
      valid   <= 1'b0;
      changed <= 1'b0;
      buttons <= 8'h00;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      latch   <= (state_nxt == S_LATCH);
      sclk    <= (state_nxt == S_HIGH);
      valid   <= publish;
      changed <= publish && ((~shift_nxt) != buttons);
      if (publish) buttons <= ~shift_nxt;
    end
  end

endmodule

// File: tb/tb_nes_poll_reader.sv
// Directed bench for nes_poll_reader with a behavioural NES controller shift register.
module tb_nes_poll_reader;

  localparam int POLL = 200;
  localparam int LATW = 4;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       data_in;
  logic       latch, sclk, valid, changed;
  logic [7:0] buttons;

  logic [7:0] pad = 8'hFF;
  logic [7:0] ctl = 8'hFF;

  int checks = 0;
  int errors = 0;

  int         f_lat, f_sclk_hi, f_rises, f_vcnt, f_voff, f_overlap;
  logic [7:0] f_btn;
  logic       f_chg;
  bit         f_hold_ok;

  nes_poll_reader #(
    .POLL_CYCLES (POLL),
    .LATCH_CYCLES(LATW),
    .HALF_CYCLES (HALF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .data_in(data_in),
    .latch  (latch),
    .sclk   (sclk),
    .buttons(buttons),
    .valid  (valid),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Controller: parallel load while latched, shift toward q on each sclk rise
  always @(posedge latch or posedge sclk) begin
    if (latch) ctl <= pad;
    else       ctl <= {1'b1, ctl[7:1]};
  end
  assign data_in = ctl[0];

  task automatic wait_latch(input int bound, output int n, output bit vseen);
    n = -1;
    vseen = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      if (valid) vseen = 1'b1;
      if (latch) begin
        n = i;
        break;
      end
    end
  endtask

  // Measures one frame starting at the sample where latch was first seen high
  task automatic capture_frame(input int drop_en_at);
    logic       prev_sclk;
    logic [7:0] first_btn;
    f_lat = 0; f_sclk_hi = 0; f_rises = 0; f_vcnt = 0; f_voff = -1; f_overlap = 0;
    f_btn = 8'hxx; f_chg = 1'bx; f_hold_ok = 1'b1;
    prev_sclk = 1'b0;
    first_btn = buttons;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (latch) f_lat++;
      if (sclk) f_sclk_hi++;
      if (latch && sclk) f_overlap++;
      if (sclk && !prev_sclk) begin
        f_rises++;
        if (f_rises == drop_en_at) en = 1'b0;
      end
      prev_sclk = sclk;
      if (valid) begin
        f_vcnt++;
        f_voff = k;
        f_btn = buttons;
        f_chg = changed;
      end
      if (k < 64 && buttons !== first_btn) f_hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  vs;
    bit  bad;
    pad = 8'h7E;
    reset = 1'b0;
    en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({latch, sclk, valid, changed, buttons} !== 12'h000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_outputs: got latch=%b sclk=%b valid=%b changed=%b buttons=%h, want all 0",
               latch, sclk, valid, changed, buttons);
    end
    reset = 1'b1;
    wait_latch(300, n, vs);
    checks++;
    if (n != POLL) begin
      errors++;
      $display("FAIL first_latch_cycle: got %0d, want %0d", n, POLL);
    end
  endtask

  task automatic test_frame_timing();
    capture_frame(0);
    checks++;
    if (f_lat != LATW) begin
      errors++;
      $display("FAIL latch_width: got %0d, want %0d", f_lat, LATW);
    end
    checks++;
    if (f_rises != 7) begin
      errors++;
      $display("FAIL sclk_pulses: got %0d, want 7", f_rises);
    end
    checks++;
    if (f_sclk_hi != 7 * HALF) begin
      errors++;
      $display("FAIL sclk_high_cycles: got %0d, want %0d", f_sclk_hi, 7 * HALF);
    end
    checks++;
    if (f_overlap != 0) begin
      errors++;
      $display("FAIL latch_sclk_overlap: got %0d, want 0", f_overlap);
    end
    checks++;
    if (f_vcnt != 1 || f_voff != 64) begin
      errors++;
      $display("FAIL valid_pulse: got count=%0d offset=%0d, want count=1 offset=64", f_vcnt, f_voff);
    end
    checks++;
    if (f_btn !== 8'h81 || f_chg !== 1'b1) begin
      errors++;
      $display("FAIL press_a_r: got buttons=%h changed=%b, want 81/1", f_btn, f_chg);
    end
  endtask

  task automatic test_repeat_and_change();
    int n;
    bit vs;
    wait_latch(300, n, vs);
    checks++;
    if (n != POLL - 79) begin
      errors++;
      $display("FAIL poll_period: got %0d, want %0d", n, POLL - 79);
    end
    capture_frame(0);
    checks++;
    if (f_vcnt != 1 || f_btn !== 8'h81 || f_chg !== 1'b0 || !f_hold_ok) begin
      errors++;
      $display("FAIL same_frame: got count=%0d buttons=%h changed=%b hold=%0d, want 1/81/0/1",
               f_vcnt, f_btn, f_chg, f_hold_ok);
    end
    pad = 8'hEF;
    wait_latch(300, n, vs);
    capture_frame(0);
    checks++;
    if (f_vcnt != 1 || f_btn !== 8'h10 || f_chg !== 1'b1) begin
      errors++;
      $display("FAIL up_only: got count=%0d buttons=%h changed=%b, want 1/10/1", f_vcnt, f_btn, f_chg);
    end
  endtask

  task automatic test_disable();
    int n;
    bit vs;
    bit act;
    en = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 3 * POLL; i++) begin
      @(posedge clk); #1;
      if (latch || sclk || valid || buttons !== 8'h10) act = 1'b1;
    end
    checks++;
    if (act) begin
      errors++;
      $display("FAIL disabled_idle: got activity or buttons=%h, want quiet and 10", buttons);
    end
    pad = 8'hFE;
    en = 1'b1;
    wait_latch(300, n, vs);
    checks++;
    if (n != POLL - 79) begin
      errors++;
      $display("FAIL reenable_latch: got %0d, want %0d", n, POLL - 79);
    end
    capture_frame(3);
    checks++;
    if (f_vcnt != 1 || f_voff != 64 || f_btn !== 8'h01 || f_chg !== 1'b1 || f_rises != 7) begin
      errors++;
      $display("FAIL en_drop_midframe: got count=%0d off=%0d buttons=%h changed=%b rises=%0d, want 1/64/01/1/7",
               f_vcnt, f_voff, f_btn, f_chg, f_rises);
    end
    act = 1'b0;
    for (int i = 0; i < 2 * POLL; i++) begin
      @(posedge clk); #1;
      if (latch || sclk || valid) act = 1'b1;
    end
    checks++;
    if (act) begin
      errors++;
      $display("FAIL no_frame_after_drop: got activity, want none");
    end
  endtask

  task automatic test_reset_midframe();
    int   n;
    bit   vs;
    int   rises;
    logic prev;
    en = 1'b1;
    pad = 8'h00;
    wait_latch(300, n, vs);
    rises = 0;
    prev = 1'b0;
    for (int k = 0; k < 80 && rises < 4; k++) begin
      @(posedge clk); #1;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    checks++;
    if (rises != 4 || sclk !== 1'b1) begin
      errors++;
      $display("FAIL reach_bit3_high: got rises=%0d sclk=%b, want 4/1", rises, sclk);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (latch !== 1'b0 || sclk !== 1'b0 || valid !== 1'b0 || buttons !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got latch=%b sclk=%b valid=%b buttons=%h, want 0/0/0/00",
               latch, sclk, valid, buttons);
    end
    repeat (3) @(negedge clk);
    pad = 8'hFF;
    reset = 1'b1;
    wait_latch(300, n, vs);
    checks++;
    if (n != POLL || vs) begin
      errors++;
      $display("FAIL latch_after_reset: got cycle=%0d valid_seen=%0d, want %0d/0", n, vs, POLL);
    end
  endtask

  task automatic test_extremes();
    int n;
    bit vs;
    capture_frame(0);
    checks++;
    if (f_vcnt != 1 || f_btn !== 8'h00 || f_chg !== 1'b0) begin
      errors++;
      $display("FAIL none_pressed: got count=%0d buttons=%h changed=%b, want 1/00/0", f_vcnt, f_btn, f_chg);
    end
    wait_latch(300, n, vs);
    capture_frame(0);
    checks++;
    if (f_vcnt != 1 || f_btn !== 8'h00 || f_chg !== 1'b0) begin
      errors++;
      $display("FAIL none_pressed_again: got count=%0d buttons=%h changed=%b, want 1/00/0", f_vcnt, f_btn, f_chg);
    end
    pad = 8'h00;
    wait_latch(300, n, vs);
    capture_frame(0);
    checks++;
    if (f_vcnt != 1 || f_btn !== 8'hFF || f_chg !== 1'b1) begin
      errors++;
      $display("FAIL all_pressed: got count=%0d buttons=%h changed=%b, want 1/FF/1", f_vcnt, f_btn, f_chg);
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_repeat_and_change();
    test_disable();
    test_reset_midframe();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
